// File: rtl/car_l2_pkg.sv
// Shared types and constants for the L2 ECC scrubber: FSM state encoding and
// error-counter width.
package car_l2_pkg;

  localparam int unsigned CntWidth = 16;

  typedef logic [2:0] scrub_state_e;

  localparam scrub_state_e StIdle  = 3'd0;
  localparam scrub_state_e StWait  = 3'd1;
  localparam scrub_state_e StRead  = 3'd2;
  localparam scrub_state_e StResp  = 3'd3;
  localparam scrub_state_e StWrite = 3'd4;

endpackage

// File: rtl/l2_scrub_satcnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module l2_scrub_satcnt
  import car_l2_pkg::*;
#(
  parameter int unsigned Width = CntWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_reg <= '0;
    end else if (clear_i) begin
      count_reg <= '0;
    end else if (inc_i && (count_reg != {Width{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count_o = count_reg;

endmodule

// File: rtl/l2_ecc_scrubber.sv
// Background ECC scrubber for one L2 bank, sharing the bank port with functional
// traffic. Optional anti-starvation override: define L2_SCRUB_ANTISTARVE_EN.
module l2_ecc_scrubber
  import car_l2_pkg::*;
#(
  parameter int unsigned NumWords      = 16384,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned IntervalWidth = 16,
  parameter int unsigned StarveMax     = 64,
  localparam int unsigned AW           = $clog2(NumWords)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic [IntervalWidth-1:0] interval_i,
  input  logic                     clear_i,
  input  logic                     func_req_i,
  input  logic                     func_we_i,
  input  logic [AW-1:0]            func_addr_i,
  input  logic [DataWidth-1:0]     func_wdata_i,
  output logic                     func_gnt_o,
  output logic                     func_rvalid_o,
  output logic [DataWidth-1:0]     func_rdata_o,
  output logic                     bank_req_o,
  output logic                     bank_we_o,
  output logic [AW-1:0]            bank_addr_o,
  output logic [DataWidth-1:0]     bank_wdata_o,
  input  logic                     bank_gnt_i,
  input  logic                     bank_rvalid_i,
  input  logic [DataWidth-1:0]     bank_rdata_i,
  input  logic                     bank_serr_i,
  input  logic                     bank_merr_i,
  output logic [CntWidth-1:0]      corr_count_o,
  output logic [CntWidth-1:0]      uncorr_count_o,
  output logic                     sweep_done_o
);

  scrub_state_e           state_reg, state_next;
  logic [IntervalWidth-1:0] cnt_reg, cnt_next;
  logic [AW-1:0]          addr_reg, addr_next;
  logic [DataWidth-1:0]   wb_data_reg;
  logic                   owner_reg;
  logic                   sweep_reg;

  logic scrub_req, sel_scrub, scrub_gnt, starve_force;
  logic fw_hit, resp_serr, resp_merr, op_done, addr_last;

  assign scrub_req = (state_reg == StRead) || (state_reg == StWrite);
  assign sel_scrub = scrub_req && (!func_req_i || starve_force);
  assign scrub_gnt = sel_scrub && bank_gnt_i;

  assign func_gnt_o   = bank_gnt_i && func_req_i && !sel_scrub;
  assign bank_req_o   = func_req_i || scrub_req;
  assign bank_we_o    = sel_scrub ? (state_reg == StWrite) : func_we_i;
  assign bank_addr_o  = sel_scrub ? addr_reg : func_addr_i;
  assign bank_wdata_o = sel_scrub ? wb_data_reg : func_wdata_i;

  // Responses to scrubber reads never leak onto the functional port.
  assign func_rvalid_o = bank_rvalid_i && !owner_reg;
  assign func_rdata_o  = func_rvalid_o ? bank_rdata_i : '0;

  assign fw_hit    = func_gnt_o && func_we_i && (func_addr_i == addr_reg);
  assign resp_serr = (state_reg == StResp) && bank_rvalid_i && bank_serr_i;
  assign resp_merr = (state_reg == StResp) && bank_rvalid_i && bank_merr_i;
  assign addr_last = (addr_reg == AW'(NumWords - 1));

`ifdef L2_SCRUB_ANTISTARVE_EN
  localparam int unsigned SW = $clog2(StarveMax + 1);
  logic [SW-1:0] starve_reg;

  assign starve_force = (starve_reg == SW'(StarveMax));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_reg <= '0;
    end else if (scrub_gnt) begin
      starve_reg <= '0;
    end else if (scrub_req && !starve_force) begin
      starve_reg <= starve_reg + 1'b1;
    end
  end
`else
  assign starve_force = 1'b0 && (StarveMax != 0);
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_done    = 1'b0;
    case (state_reg)
      StIdle: begin
        if (enable_i) begin
          state_next = StWait;
          cnt_next   = interval_i;
        end
      end
      StWait: begin
        // Leaving on the count that decrements to zero keeps WAIT exactly
        // interval_i cycles long (minimum one).
        if (!enable_i) begin
          state_next = StIdle;
        end else if (cnt_reg <= IntervalWidth'(1)) begin
          state_next = StRead;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      StRead: begin
        if (scrub_gnt) state_next = StResp;
      end
      StResp: begin
        if (resp_serr && !fw_hit) begin
          state_next = StWrite;
        end else begin
          state_next = StWait;
          cnt_next   = interval_i;
          op_done    = 1'b1;
        end
      end
      StWrite: begin
        // A functional write to the same word makes our corrected copy stale.
        if (scrub_gnt || fw_hit) begin
          state_next = StWait;
          cnt_next   = interval_i;
          op_done    = 1'b1;
        end
      end
      default: state_next = StIdle;
    endcase
  end

  always_comb begin
    addr_next = addr_reg;
    if (op_done) addr_next = addr_last ? '0 : addr_reg + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= StIdle;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      wb_data_reg <= '0;
      owner_reg   <= 1'b0;
      sweep_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      sweep_reg <= op_done && addr_last;
      if (state_reg == StResp) wb_data_reg <= bank_rdata_i;
      if (bank_req_o && bank_gnt_i && !bank_we_o) owner_reg <= sel_scrub;
    end
  end

  assign sweep_done_o = sweep_reg;

  logic [1:0]          cnt_inc;
  logic [CntWidth-1:0] cnt_val [2];

  assign cnt_inc = {resp_merr, resp_serr};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    l2_scrub_satcnt #(
      .Width(CntWidth)
    ) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clear_i(clear_i),
      .inc_i  (cnt_inc[gi]),
      .count_o(cnt_val[gi])
    );
  end

  assign corr_count_o   = cnt_val[0];
  assign uncorr_count_o = cnt_val[1];

endmodule
